// File: rtl/afe_spi_pkg.sv
// afe_spi_pkg: shared types and constants for the AFE serial writer.
//   state_e     - transaction FSM states
//   MIN_*       - lowest legal parameter values
//   phase_count - number of SPI phases in one transaction
package afe_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    LATCH = 3'd4,
    GAP   = 3'd5
  } state_e;

  localparam int unsigned MIN_WORD_WIDTH  = 1;
  localparam int unsigned MIN_HALF_PERIOD = 1;
  localparam int unsigned MIN_LE_PHASES   = 1;
  // Shortest legal transaction: one bit, one LE phase.
  localparam int unsigned MIN_PHASES      = 2 * MIN_WORD_WIDTH + MIN_LE_PHASES + 2;

  // SETUP + (HIGH, LOW) per bit + LATCH phases + GAP.
  function automatic int unsigned phase_count(input int unsigned word_width,
                                              input int unsigned le_phases);
    return 2 * word_width + le_phases + 2;
  endfunction

endpackage

// File: rtl/afe_spi_tick.sv
// afe_spi_tick: HALF_PERIOD prescaler producing a one-cycle phase-end strobe.
//   clk_i       - system clock
//   rst_ni      - async active-low reset
//   restart_i   - synchronous restart; the next cycle is the first of a phase
//   phase_end_o - registered strobe, high in the last cycle of each phase
module afe_spi_tick #(
  parameter int unsigned HALF_PERIOD = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic phase_end_o
);

  localparam int unsigned CNT_W = $clog2(HALF_PERIOD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_end_q;

  // Counter position for the next cycle.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || cnt_q == LAST) cnt_d = '0;
  end

  // Strobe is registered from the next count so it lines up with the last cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      phase_end_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_end_q <= (cnt_d == LAST);
    end
  end

  assign phase_end_o = phase_end_q;

endmodule

// File: rtl/afe_spi_writer.sv
// afe_spi_writer: shifts a CPU word MSB-first to one of two AFE boards, then
// pulses that board's latch enable.
//   sysClk, sysReset_n       - clock, async active-low reset
//   start, sel, txData       - request strobe, board select, word (sampled with start)
//   busy, done, overrun      - in progress, end-of-transaction pulse, sticky start-while-busy
//   AFE_SPI_CLK/SDI/LE [1:0] - per-board SPI pins, unselected board held at 0
module afe_spi_writer
  import afe_spi_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned HALF_PERIOD = 5,
  parameter int unsigned LE_PHASES   = 2
) (
  input  logic                  sysClk,
  input  logic                  sysReset_n,
  input  logic                  start,
  input  logic                  sel,
  input  logic [WORD_WIDTH-1:0] txData,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [1:0]            AFE_SPI_CLK,
  output logic [1:0]            AFE_SPI_SDI,
  output logic [1:0]            AFE_SPI_LE
);

  localparam int unsigned BIT_W = $clog2(WORD_WIDTH + 1);
  localparam int unsigned LE_W  = $clog2(LE_PHASES + 1);

  if (WORD_WIDTH < MIN_WORD_WIDTH) begin : g_bad_word_width
    $error("WORD_WIDTH below minimum");
  end
  if (HALF_PERIOD < MIN_HALF_PERIOD) begin : g_bad_half_period
    $error("HALF_PERIOD below minimum");
  end
  if (LE_PHASES < MIN_LE_PHASES) begin : g_bad_le_phases
    $error("LE_PHASES below minimum");
  end
  if (phase_count(WORD_WIDTH, LE_PHASES) < MIN_PHASES) begin : g_bad_phase_count
    $error("transaction shorter than minimum");
  end

  state_e                 state_q;
  logic                   sel_q;
  logic [WORD_WIDTH-1:0]  shift_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic [LE_W-1:0]        le_cnt_q;
  logic                   busy_q, done_q, overrun_q;
  logic [1:0]             clk_q, sdi_q, le_q;

  logic                   accept_c;
  logic                   phase_end_c;
  logic [1:0]             sel_mask_c, start_mask_c;
  logic [WORD_WIDTH-1:0]  shift_nxt_c;

  assign accept_c     = start && (state_q == IDLE);
  assign sel_mask_c   = sel_q ? 2'b10 : 2'b01;
  assign start_mask_c = sel ? 2'b10 : 2'b01;
  // Zeros shift in, so the MSB is 0 once every data bit has gone out.
  assign shift_nxt_c  = shift_q << 1;

  afe_spi_tick #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_tick (
    .clk_i       (sysClk),
    .rst_ni      (sysReset_n),
    .restart_i   (accept_c),
    .phase_end_o (phase_end_c)
  );

  // Transaction FSM; per-board pins are registered with the select mask applied.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      le_cnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      clk_q     <= 2'b00;
      sdi_q     <= 2'b00;
      le_q      <= 2'b00;
    end else begin
      done_q <= 1'b0;
      if (accept_c) begin
        state_q   <= SETUP;
        sel_q     <= sel;
        shift_q   <= txData;
        bit_cnt_q <= BIT_W'(WORD_WIDTH);
        busy_q    <= 1'b1;
        overrun_q <= 1'b0;
        clk_q     <= 2'b00;
        le_q      <= 2'b00;
        sdi_q     <= txData[WORD_WIDTH-1] ? start_mask_c : 2'b00;
      end else begin
        // Not accepted, so any start here arrived while busy.
        if (start) overrun_q <= 1'b1;
        if (phase_end_c) begin
          case (state_q)
            SETUP: begin
              state_q <= HIGH;
              clk_q   <= sel_mask_c;
            end
            HIGH: begin
              state_q   <= LOW;
              clk_q     <= 2'b00;
              shift_q   <= shift_nxt_c;
              bit_cnt_q <= bit_cnt_q - BIT_W'(1);
              sdi_q     <= shift_nxt_c[WORD_WIDTH-1] ? sel_mask_c : 2'b00;
            end
            LOW: begin
              if (bit_cnt_q != '0) begin
                state_q <= HIGH;
                clk_q   <= sel_mask_c;
              end else begin
                state_q  <= LATCH;
                sdi_q    <= 2'b00;
                le_q     <= sel_mask_c;
                le_cnt_q <= LE_W'(LE_PHASES);
              end
            end
            LATCH: begin
              if (le_cnt_q == LE_W'(1)) begin
                state_q <= GAP;
                le_q    <= 2'b00;
              end else begin
                le_cnt_q <= le_cnt_q - LE_W'(1);
              end
            end
            GAP: begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign AFE_SPI_CLK = clk_q;
  assign AFE_SPI_SDI = sdi_q;
  assign AFE_SPI_LE  = le_q;

endmodule

// File: tb/tb_afe_spi_writer.sv
// tb_afe_spi_writer: directed bench for afe_spi_writer (default build plus a
// HALF_PERIOD=1 / WORD_WIDTH=8 / LE_PHASES=1 build).
module tb_afe_spi_writer;
  import afe_spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start0, sel0;
  logic [15:0] tx0;
  logic        busy0, done0, ovr0;
  logic [1:0]  sclk0, sdi0, le0;

  logic        start1, sel1;
  logic [7:0]  tx1;
  logic        busy1, done1, ovr1;
  logic [1:0]  sclk1, sdi1, le1;

  always #5 clk = ~clk;

  afe_spi_writer u_dut0 (
    .sysClk      (clk),
    .sysReset_n  (rst_n),
    .start       (start0),
    .sel         (sel0),
    .txData      (tx0),
    .busy        (busy0),
    .done        (done0),
    .overrun     (ovr0),
    .AFE_SPI_CLK (sclk0),
    .AFE_SPI_SDI (sdi0),
    .AFE_SPI_LE  (le0)
  );

  afe_spi_writer #(
    .WORD_WIDTH  (8),
    .HALF_PERIOD (1),
    .LE_PHASES   (1)
  ) u_dut1 (
    .sysClk      (clk),
    .sysReset_n  (rst_n),
    .start       (start1),
    .sel         (sel1),
    .txData      (tx1),
    .busy        (busy1),
    .done        (done1),
    .overrun     (ovr1),
    .AFE_SPI_CLK (sclk1),
    .AFE_SPI_SDI (sdi1),
    .AFE_SPI_LE  (le1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-transaction observations on the default DUT.
  int          busy_cnt, done_cyc, end_cyc, rises, le_cnt, le_first;
  int          first_rise, last_fall, other, viol, sdi_hi_clk;
  logic        ovr_at1;
  logic [15:0] word_rx;

  // Called #1 after a posedge; start is presented in that same cycle (cycle 0).
  task automatic run_txn(input logic s, input logic [15:0] d, input int inject_at);
    logic pclk, psdi;
    busy_cnt = 0; done_cyc = -1; end_cyc = -1; rises = 0; le_cnt = 0; le_first = -1;
    first_rise = -1; last_fall = -1; other = 0; viol = 0; sdi_hi_clk = 0;
    ovr_at1 = 1'b0; word_rx = '0; pclk = 1'b0; psdi = 1'b0;
    sel0 = s; tx0 = d; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    sel0 = !s; tx0 = ~d;
    for (int c = 1; c <= 400; c++) begin
      if (c == 1) ovr_at1 = ovr0;
      if (done0) done_cyc = c;
      if (sclk0[s] && !pclk) begin
        rises++;
        word_rx = {word_rx[14:0], sdi0[s]};
        if (first_rise < 0) first_rise = c;
      end
      if (!sclk0[s] && pclk) last_fall = c;
      if (sclk0[s] && pclk && (sdi0[s] != psdi)) viol++;
      if (sclk0[s] && sdi0[s]) sdi_hi_clk++;
      if (le0[s]) begin
        le_cnt++;
        if (le_first < 0) le_first = c;
        if (sclk0[s] || sdi0[s]) viol++;
      end
      if (sclk0[!s] || sdi0[!s] || le0[!s]) other++;
      pclk = sclk0[s];
      psdi = sdi0[s];
      if (!busy0) begin
        end_cyc = c;
        break;
      end
      busy_cnt++;
      if (c == inject_at) begin
        start0 = 1'b1; sel0 = !s; tx0 = ~d;
      end
      @(posedge clk); #1;
      start0 = 1'b0;
    end
  endtask

  initial begin
    logic le_seen;
    int   b1, t1, r1, l1, e1, d1;
    logic p1;
    logic [7:0] w1;

    rst_n = 1'b0;
    start0 = 1'b0; sel0 = 1'b0; tx0 = '0;
    start1 = 1'b0; sel1 = 1'b0; tx1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy",    32'(busy0), 32'd0);
    check_eq("rst_done",    32'(done0), 32'd0);
    check_eq("rst_overrun", 32'(ovr0),  32'd0);
    check_eq("rst_clk",     32'(sclk0), 32'd0);
    check_eq("rst_sdi",     32'(sdi0),  32'd0);
    check_eq("rst_le",      32'(le0),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Board 0, A5C3.
    run_txn(1'b0, 16'hA5C3, 0);
    check_eq("t1_busy_cycles", 32'(busy_cnt),   32'd180);
    check_eq("t1_busy_helper", 32'(busy_cnt),   32'(5 * phase_count(16, 2)));
    check_eq("t1_done_cycle",  32'(done_cyc),   32'd181);
    check_eq("t1_end_cycle",   32'(end_cyc),    32'd181);
    check_eq("t1_rises",       32'(rises),      32'd16);
    check_eq("t1_word",        32'(word_rx),    32'h0000A5C3);
    check_eq("t1_first_rise",  32'(first_rise), 32'd6);
    check_eq("t1_last_fall",   32'(last_fall),  32'd161);
    check_eq("t1_le_first",    32'(le_first),   32'd166);
    check_eq("t1_le_cycles",   32'(le_cnt),     32'd10);
    check_eq("t1_board1_idle", 32'(other),      32'd0);
    check_eq("t1_sdi_stable",  32'(viol),       32'd0);

    // Board 1, single LSB set.
    run_txn(1'b1, 16'h0001, 0);
    check_eq("t2_word",        32'(word_rx),    32'h00000001);
    check_eq("t2_rises",       32'(rises),      32'd16);
    check_eq("t2_sdi_hi_clk",  32'(sdi_hi_clk), 32'd5);
    check_eq("t2_board0_idle", 32'(other),      32'd0);
    check_eq("t2_busy_cycles", 32'(busy_cnt),   32'd180);

    // Start at cycle 50 of a transaction is ignored and flagged.
    run_txn(1'b0, 16'h1234, 50);
    check_eq("t3_word",        32'(word_rx),    32'h00001234);
    check_eq("t3_board1_idle", 32'(other),      32'd0);
    check_eq("t3_busy_cycles", 32'(busy_cnt),   32'd180);
    check_eq("t3_overrun_set", 32'(ovr0),       32'd1);

    // Back-to-back: start in the first cycle busy is low; clears overrun.
    run_txn(1'b0, 16'hBEEF, 0);
    check_eq("t4_overrun_clr", 32'(ovr_at1),    32'd0);
    check_eq("t4_busy_cycles", 32'(busy_cnt),   32'd180);
    check_eq("t4_done_cycle",  32'(done_cyc),   32'd181);
    check_eq("t4_word",        32'(word_rx),    32'h0000BEEF);

    // Start coinciding with the final GAP cycle is ignored and flagged.
    run_txn(1'b1, 16'h8001, 180);
    check_eq("t5_word",        32'(word_rx),    32'h00008001);
    check_eq("t5_overrun_set", 32'(ovr0),       32'd1);
    @(posedge clk); #1;
    check_eq("t5_not_accepted", 32'(busy0),     32'd0);

    // Reset at cycle 90 of a transaction.
    sel0 = 1'b0; tx0 = 16'hFFFF; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (89) @(posedge clk);
    #1;
    check_eq("t6_busy_pre",    32'(busy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_busy_async",  32'(busy0), 32'd0);
    check_eq("t6_clk_async",   32'(sclk0), 32'd0);
    check_eq("t6_sdi_async",   32'(sdi0),  32'd0);
    check_eq("t6_le_async",    32'(le0),   32'd0);
    le_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      le_seen = le_seen | (|le0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_no_le",       32'(le_seen), 32'd0);
    check_eq("t6_ovr_cleared", 32'(ovr0),    32'd0);
    run_txn(1'b0, 16'h3C5A, 0);
    check_eq("t6_word",        32'(word_rx),  32'h00003C5A);
    check_eq("t6_busy_cycles", 32'(busy_cnt), 32'd180);
    check_eq("t6_le_cycles",   32'(le_cnt),   32'd10);

    // Minimal build: HALF_PERIOD=1, WORD_WIDTH=8, LE_PHASES=1.
    b1 = 0; t1 = 0; r1 = 0; l1 = 0; e1 = -1; d1 = -1; p1 = 1'b0; w1 = '0;
    sel1 = 1'b0; tx1 = 8'h96; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; tx1 = 8'h00;
    for (int c = 1; c <= 100; c++) begin
      if (done1) d1 = c;
      if (sclk1[0] != p1) t1++;
      if (sclk1[0] && !p1) begin
        r1++;
        w1 = {w1[6:0], sdi1[0]};
      end
      if (le1[0]) l1++;
      p1 = sclk1[0];
      if (!busy1) begin
        e1 = c;
        break;
      end
      b1++;
      @(posedge clk); #1;
    end
    check_eq("t7_busy_cycles", 32'(b1), 32'd19);
    check_eq("t7_done_cycle",  32'(d1), 32'd20);
    check_eq("t7_end_cycle",   32'(e1), 32'd20);
    check_eq("t7_toggles",     32'(t1), 32'd16);
    check_eq("t7_rises",       32'(r1), 32'd8);
    check_eq("t7_word",        32'(w1), 32'h00000096);
    check_eq("t7_le_cycles",   32'(l1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
